rs_alu_sched: RTL and testbench



---
 rtl/rs_alu_sched.sv | 121 ++++++++++++
 tb/tb_rs_alu_sched.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rs_alu_sched.sv
// rs_alu_sched: ALU reservation-station scheduler.
// It allocates the lowest free RS line on issue. It keeps an age matrix so it can
// dispatch the oldest operand-ready line to the single ALU. It then runs the
// IDLE -> EXEC -> RESULT sequence through execute and CDB broadcast and frees the line.
//
// state  | meaning
// IDLE   | waiting for a ready line; picks the oldest and latches fu_sel
// EXEC   | ALU busy on fu_sel; fu_start pulses on the first cycle
// RESULT | result held; requesting the CDB until granted, then free the line
module rs_alu_sched #(
  parameter int           N        = 4,
  parameter int           IW       = $clog2(N),
  parameter logic [7:0]   TAG_BASE = 8'h10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          issue_req,
  output logic          issue_ack,
  output logic [N-1:0]  line_issue,
  output logic          rs_full,
  input  logic [N-1:0]  line_busy,
  input  logic [N-1:0]  line_ready,
  output logic [N-1:0]  line_taken,
  output logic          fu_start,
  output logic [IW-1:0] fu_sel,
  input  logic          fu_done,
  output logic          cdb_req,
  input  logic          cdb_grant,
  output logic [7:0]    cdb_tag
);

  typedef enum logic [1:0] {IDLE, EXEC, RESULT} state_t;

  state_t         state;
  logic           start_q;
  logic [IW-1:0]  issue_idx;
  logic [IW-1:0]  pick_idx;
  logic [N-1:0]   rdy;
  logic [N-1:0]   cand;
  // older[j][i] set means line j was issued before line i
  logic [N-1:0]   older [N];

  assign rs_full = &line_busy;
  assign issue_ack = issue_req & ~rs_full & ~flush;
  assign line_issue = issue_ack ? ({{(N-1){1'b0}}, 1'b1} << issue_idx) : '0;
  assign cdb_tag = TAG_BASE + {{(8-IW){1'b0}}, fu_sel};

  // The registered state alone decides these outputs; flush forces them off in its own cycle.
  assign fu_start = start_q & ~flush;
  assign cdb_req = (state == RESULT) & ~flush;
  assign line_taken = (cdb_req & cdb_grant) ? ({{(N-1){1'b0}}, 1'b1} << fu_sel) : '0;

  // Find the lowest-index free line for allocation.
  always_comb begin
    issue_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!line_busy[i]) issue_idx = IW'(i);
    end
  end

  // Pick the ready line that no other ready line is older than.
  always_comb begin
    rdy = line_ready & line_busy;
    cand = rdy;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (rdy[j] && older[j][i]) cand[i] = 1'b0;
      end
    end
    pick_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) pick_idx = IW'(i);
    end
  end

  // Age matrix: a newly issued line is younger than every line busy in its issue cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) older[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < N; i++) older[i] <= '0;
    end else if (issue_ack) begin
      older[issue_idx] <= '0;
      for (int j = 0; j < N; j++) begin
        if (j != int'(issue_idx)) older[j][issue_idx] <= line_busy[j];
      end
    end
  end

  // Dispatch FSM. fu_sel is only updated in IDLE, so it stays stable through EXEC and RESULT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      fu_sel  <= '0;
      start_q <= 1'b0;
    end else if (flush) begin
      state   <= IDLE;
      start_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state)
        IDLE: begin
          if (|rdy) begin
            fu_sel  <= pick_idx;
            start_q <= 1'b1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          if (fu_done) state <= RESULT;
        end
        RESULT: begin
          if (cdb_grant) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_alu_sched.sv
// Directed bench for rs_alu_sched. It models the RS lines: busy is set on line_issue
// and cleared on line_taken or flush, and ready is busy masked by a bench-driven pattern.
module tb_rs_alu_sched;

  localparam int N = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          issue_req;
  logic          issue_ack;
  logic [N-1:0]  line_issue;
  logic          rs_full;
  logic [N-1:0]  line_busy;
  logic [N-1:0]  line_ready;
  logic [N-1:0]  line_taken;
  logic          fu_start;
  logic [IW-1:0] fu_sel;
  logic          fu_done;
  logic          cdb_req;
  logic          cdb_grant;
  logic [7:0]    cdb_tag;
  logic [N-1:0]  rdy_mask;

  int n_cmp = 0;
  int n_bad = 0;

  rs_alu_sched #(.N(N), .IW(IW), .TAG_BASE(8'h10)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .issue_req(issue_req), .issue_ack(issue_ack), .line_issue(line_issue), .rs_full(rs_full),
    .line_busy(line_busy), .line_ready(line_ready), .line_taken(line_taken),
    .fu_start(fu_start), .fu_sel(fu_sel), .fu_done(fu_done),
    .cdb_req(cdb_req), .cdb_grant(cdb_grant), .cdb_tag(cdb_tag)
  );

  always #5 clk = ~clk;

  // RS line model
  always_ff @(posedge clk or posedge rst) begin
    if (rst) line_busy <= '0;
    else if (flush) line_busy <= '0;
    else line_busy <= (line_busy & ~line_taken) | line_issue;
  end
  assign line_ready = line_busy & rdy_mask;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; issue_req = 1'b0; fu_done = 1'b0;
    cdb_grant = 1'b0; rdy_mask = '0;
    next_cycle();
    chk("rst_fu_start", fu_start, 0);
    chk("rst_cdb_req", cdb_req, 0);
    chk("rst_line_taken", line_taken, 0);
    chk("rst_line_issue", line_issue, 0);
    chk("rst_issue_ack", issue_ack, 0);
    chk("rst_fu_sel", fu_sel, 0);
    chk("rst_cdb_tag", cdb_tag, 32'h10);
    chk("rst_rs_full", rs_full, 0);
    rst = 1'b0;

    // fill all four lines, then a fifth request is refused
    issue_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("alloc_ack", issue_ack, 1);
      chk("alloc_onehot", line_issue, 32'(1 << i));
      next_cycle();
    end
    @(negedge clk);
    chk("full_ack", issue_ack, 0);
    chk("full_flag", rs_full, 1);
    chk("full_issue", line_issue, 0);
    issue_req = 1'b0;

    // oldest-ready pick: lines 0,1,2 issued; 1 and 2 ready together
    do_reset();
    issue_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("age_issue", line_issue, 32'(1 << i));
      next_cycle();
    end
    issue_req = 1'b0;
    rdy_mask = 4'b0110;
    @(negedge clk);
    chk("age_no_start_yet", fu_start, 0);
    next_cycle();
    fu_done = 1'b1;
    @(negedge clk);
    chk("age_fu_start", fu_start, 1);
    chk("age_fu_sel", fu_sel, 1);
    chk("age_cdb_tag", cdb_tag, 32'h11);
    next_cycle();
    fu_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wait_cdb_req", cdb_req, 1);
      chk("wait_no_taken", line_taken, 0);
      chk("wait_no_restart", fu_start, 0);
      next_cycle();
    end
    cdb_grant = 1'b1;
    @(negedge clk);
    chk("grant_cdb_req", cdb_req, 1);
    chk("grant_taken", line_taken, 32'b0010);
    next_cycle();
    cdb_grant = 1'b0;
    @(negedge clk);
    chk("after_grant_req", cdb_req, 0);
    chk("after_grant_start", fu_start, 0);
    next_cycle();
    fu_done = 1'b1;
    @(negedge clk);
    chk("second_start", fu_start, 1);
    chk("second_sel", fu_sel, 2);
    chk("second_tag", cdb_tag, 32'h12);
    next_cycle();
    fu_done = 1'b0;
    cdb_grant = 1'b1;
    @(negedge clk);
    chk("second_taken", line_taken, 32'b0100);
    next_cycle();
    cdb_grant = 1'b0;
    rdy_mask = '0;

    // free and issue in the same cycle: line 3 is not allocatable until the next cycle
    do_reset();
    issue_req = 1'b1;
    for (int i = 0; i < 4; i++) next_cycle();
    issue_req = 1'b0;
    rdy_mask = 4'b1000;
    next_cycle();
    fu_done = 1'b1;
    @(negedge clk);
    chk("full_sel3", fu_sel, 3);
    next_cycle();
    fu_done = 1'b0;
    cdb_grant = 1'b1;
    issue_req = 1'b1;
    @(negedge clk);
    chk("same_cyc_ack", issue_ack, 0);
    chk("same_cyc_taken", line_taken, 32'b1000);
    next_cycle();
    cdb_grant = 1'b0;
    rdy_mask = '0;
    @(negedge clk);
    chk("reissue_ack", issue_ack, 1);
    chk("reissue_line", line_issue, 32'b1000);
    next_cycle();
    issue_req = 1'b0;
    rdy_mask = 4'b1001;
    next_cycle();
    fu_done = 1'b1;
    @(negedge clk);
    chk("reissued_younger_sel", fu_sel, 0);
    chk("reissued_start", fu_start, 1);
    next_cycle();

    // flush while in RESULT with a grant
    fu_done = 1'b0;
    cdb_grant = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_taken", line_taken, 0);
    chk("flush_cdb_req", cdb_req, 0);
    chk("flush_issue", line_issue, 0);
    next_cycle();
    flush = 1'b0;
    cdb_grant = 1'b0;
    rdy_mask = '0;
    issue_req = 1'b1;
    @(negedge clk);
    chk("post_flush_req", cdb_req, 0);
    chk("post_flush_start", fu_start, 0);
    chk("post_flush_issue", line_issue, 32'b0001);
    next_cycle();
    next_cycle();
    issue_req = 1'b0;
    rdy_mask = 4'b0010;
    next_cycle();
    @(negedge clk);
    chk("pre_rst_start", fu_start, 1);
    chk("pre_rst_sel", fu_sel, 1);

    // asynchronous reset mid-EXEC
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_start", fu_start, 0);
    chk("async_rst_req", cdb_req, 0);
    chk("async_rst_sel", fu_sel, 0);
    chk("async_rst_tag", cdb_tag, 32'h10);
    #1;
    rst = 1'b0;
    rdy_mask = '0;
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
